// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 32;

  localparam logic [1:0] WE_ON  = 2'b01;
  localparam logic [1:0] WE_OFF = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_PEND = 2'd1,
    D_PEND = 2'd2
  } ret_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = mem_port_arbiter_pkg::AW_DEF,
  parameter int DW = mem_port_arbiter_pkg::DW_DEF
);
  logic          F_REQ;
  logic [AW-1:0] F_ADDR;
  logic          F_GNT;
  logic          F_RVALID;
  logic          D_REQ;
  logic          D_WE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_LOCK;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] MRA;
  logic [DW-1:0] MWD;
  logic [1:0]    MWE;
  logic [DW-1:0] MRD;
  logic [1:0]    IRWE;

  // Environment side: both requesters plus the memory read-data return.
  modport master (
    output F_REQ, F_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_LOCK, MRD,
    input  F_GNT, F_RVALID, D_GNT, D_RVALID, RDATA, MRA, MWD, MWE, IRWE
  );

  modport slave (
    input  F_REQ, F_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_LOCK, MRD,
    output F_GNT, F_RVALID, D_GNT, D_RVALID, RDATA, MRA, MWD, MWE, IRWE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (F) and load/store (D)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input logic CLK,
  input logic RST_N,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  ret_state_t    state, state_next;
  logic          f_win, d_win;
  logic          lock_held;
  logic [3:0]    starve_cnt;
  logic [AW-1:0] mra_q;
  logic [AW-1:0] mra_next;

  // Grants are gated by RST_N so nothing reaches the memory while reset is held.
  always_comb begin
    f_win = 1'b0;
    d_win = 1'b0;
    if (RST_N) begin
      if (bus.D_REQ &&
          !(bus.F_REQ && !lock_held && (starve_cnt == STARVE_MAX))) begin
        d_win = 1'b1;
      end else if (bus.F_REQ && !lock_held) begin
        f_win = 1'b1;
      end
    end
  end

  always_comb begin
    mra_next = mra_q;
    if (f_win) begin
      mra_next = bus.F_ADDR;
    end else if (d_win) begin
      mra_next = bus.D_ADDR;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= 4'd0;
      lock_held  <= 1'b0;
      mra_q      <= '0;
    end else begin
      if (!bus.F_REQ || f_win) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (!bus.D_LOCK) begin
        lock_held <= 1'b0;
      end else if (d_win) begin
        lock_held <= 1'b1;
      end

      mra_q <= mra_next;
    end
  end

  // Read-return tracker: state register / next-state / outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (f_win) begin
      state_next = F_PEND;
    end else if (d_win && !bus.D_WE) begin
      state_next = D_PEND;
    end
  end

  always_comb begin
    bus.F_GNT    = f_win;
    bus.D_GNT    = d_win;
    bus.MRA      = mra_next;
    bus.MWD      = bus.D_WDATA;
    bus.MWE      = (d_win && bus.D_WE) ? WE_ON : WE_OFF;
    bus.RDATA    = bus.MRD;
    bus.F_RVALID = (state == F_PEND);
    bus.D_RVALID = (state == D_PEND);
    bus.IRWE     = (state == F_PEND) ? WE_ON : WE_OFF;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_f;
    logic [31:0] data;
  } ret_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  mem_port_arbiter_if #(.AW(9), .DW(32)) bus ();

  mem_port_arbiter #(.AW(9), .STARVE_LIMIT(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem     [512];
  logic [31:0] exp_mem [512];
  ret_t        q[$];
  logic [8:0]  last_mra;
  int          total = 0;
  int          bad   = 0;

  // Registered single-port memory driven by the arbiter.
  always @(posedge CLK) begin
    if (bus.MWE == 2'b01) mem[bus.MRA] <= bus.MWD;
    bus.MRD <= mem[bus.MRA];
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_return(input string tag);
    ret_t e;
    expect_eq({tag, ".rv_any"}, 32'(bus.F_RVALID || bus.D_RVALID), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q.pop_front();
      expect_eq({tag, ".f_rvalid"}, 32'(bus.F_RVALID), 32'(e.is_f));
      expect_eq({tag, ".d_rvalid"}, 32'(bus.D_RVALID), 32'(!e.is_f));
      expect_eq({tag, ".irwe"}, 32'(bus.IRWE), e.is_f ? 32'd1 : 32'd0);
      expect_eq({tag, ".rdata"}, bus.RDATA, e.data);
    end else begin
      expect_eq({tag, ".irwe"}, 32'(bus.IRWE), 32'd0);
    end
  endtask

  // One clock: check returns, expected grant and memory drive, update the scoreboard.
  task automatic step(input string tag, input logic ef, input logic ed);
    @(negedge CLK);
    check_return(tag);
    expect_eq({tag, ".f_gnt"}, 32'(bus.F_GNT), 32'(ef));
    expect_eq({tag, ".d_gnt"}, 32'(bus.D_GNT), 32'(ed));
    if (ef) last_mra = bus.F_ADDR;
    if (ed) last_mra = bus.D_ADDR;
    expect_eq({tag, ".mra"}, 32'(bus.MRA), 32'(last_mra));
    expect_eq({tag, ".mwe"}, 32'(bus.MWE), (ed && bus.D_WE) ? 32'd1 : 32'd0);
    if (ef) q.push_back('{is_f: 1'b1, data: exp_mem[bus.F_ADDR]});
    if (ed && !bus.D_WE) q.push_back('{is_f: 1'b0, data: exp_mem[bus.D_ADDR]});
    if (ed && bus.D_WE) exp_mem[bus.D_ADDR] = bus.D_WDATA;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, ".f_gnt"}, 32'(bus.F_GNT), 32'd0);
    expect_eq({tag, ".d_gnt"}, 32'(bus.D_GNT), 32'd0);
    expect_eq({tag, ".mwe"}, 32'(bus.MWE), 32'd0);
    expect_eq({tag, ".f_rvalid"}, 32'(bus.F_RVALID), 32'd0);
    expect_eq({tag, ".d_rvalid"}, 32'(bus.D_RVALID), 32'd0);
    expect_eq({tag, ".irwe"}, 32'(bus.IRWE), 32'd0);
    expect_eq({tag, ".mra"}, 32'(bus.MRA), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'(i * 3);
      exp_mem[i] = 32'(i * 3);
    end
    mem[20] = 32'd17;  exp_mem[20] = 32'd17;
    mem[21] = 32'd31;  exp_mem[21] = 32'd31;
    mem[22] = -32'sd5; exp_mem[22] = -32'sd5;
    mem[23] = -32'sd2; exp_mem[23] = -32'sd2;
    bus.MRD = '0;
    bus.F_REQ = 0; bus.F_ADDR = '0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = '0; bus.D_WDATA = '0; bus.D_LOCK = 0;
    last_mra = '0;

    // Reset state, requests asserted to confirm grants are held off.
    bus.F_REQ = 1; bus.F_ADDR = 9'd20; bus.D_REQ = 1; bus.D_ADDR = 9'd21;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst0");
    @(posedge CLK); #1;
    bus.F_REQ = 0; bus.D_REQ = 0;
    RST_N = 1;

    // Fetch only.
    bus.F_REQ = 1; bus.F_ADDR = 9'd20;
    step("fetch", 1, 0);
    bus.F_REQ = 0;
    step("fetch_ret", 0, 0);

    // Both requesting: D wins until F has waited STARVE_LIMIT cycles.
    bus.F_REQ = 1; bus.F_ADDR = 9'd20;
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 9'd21;
    for (int i = 0; i < 4; i++) step($sformatf("starve_d%0d", i), 0, 1);
    step("starve_f", 1, 0);
    bus.F_REQ = 0; bus.D_REQ = 0;
    step("starve_ret", 0, 0);

    // Write then read-after-write on the same address.
    bus.D_REQ = 1; bus.D_WE = 1; bus.D_ADDR = 9'd24; bus.D_WDATA = 32'h55;
    step("wr24", 0, 1);
    bus.D_WE = 0;
    step("rd24", 0, 1);
    bus.D_REQ = 0;
    step("rd24_ret", 0, 0);

    // Locked D sequence keeps F out even when starved.
    bus.F_REQ = 1; bus.F_ADDR = 9'd20;
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 9'd21; bus.D_LOCK = 1;
    for (int i = 0; i < 8; i++) step($sformatf("lock%0d", i), 0, 1);
    bus.D_REQ = 0; bus.D_LOCK = 0;
    step("unlock", 0, 0);
    step("lock_f", 1, 0);
    bus.F_REQ = 0;
    step("lock_ret", 0, 0);

    // Reset one cycle after a D read grant drops the pending return.
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 9'd21;
    step("pre_rst", 0, 1);
    RST_N = 0;
    bus.F_REQ = 1; bus.F_ADDR = 9'd20;
    @(negedge CLK);
    check_reset_outputs("rst1");
    q.delete();
    last_mra = '0;
    @(posedge CLK); #1;
    RST_N = 1;
    bus.D_REQ = 0;
    step("post_rst_f", 1, 0);
    bus.F_REQ = 0;
    step("post_rst_ret", 0, 0);

    // Alternating single-requester reads, one grant per cycle.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        bus.D_REQ = 0; bus.F_REQ = 1; bus.F_ADDR = 9'd22;
        step($sformatf("alt%0d", i), 1, 0);
      end else begin
        bus.F_REQ = 0; bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 9'd23;
        step($sformatf("alt%0d", i), 0, 1);
      end
    end
    bus.F_REQ = 0; bus.D_REQ = 0;
    step("alt_ret", 0, 0);
    step("drain", 0, 0);
    expect_eq("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port unified instruction/data memory of the multicycle processor between two requesters: the fetch port (F) and the load/store port (D). It accepts one access per cycle, drives the memory's address, write-data and write-enable inputs, and routes the one-cycle-late registered read data back to the requester that issued the read. It also generates the instruction-register write enable for returning fetches. The block sits between the control/datapath and the memory instance.

## Interface
- AW, 9: memory word-address width (512 words)
- DW, 32: data width
- STARVE_LIMIT, 4: consecutive cycles F may be denied (D ahead of it) before F gets priority; range 1..15
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- F_REQ  in  1  fetch read request, held until F_GNT
- F_ADDR  in  AW  fetch address
- F_GNT  out  1  fetch accepted this cycle
- F_RVALID  out  1  fetch read data valid
- D_REQ  in  1  data request, held until D_GNT
- D_WE  in  1  1 = write, 0 = read
- D_ADDR  in  AW  data address
- D_WDATA  in  DW  write data
- D_LOCK  in  1  hold memory ownership for D (read-modify-write)
- D_GNT  out  1  data access accepted this cycle
- D_RVALID  out  1  data read data valid
- RDATA  out  DW  read data, shared by both ports
- MRA  out  AW  memory address
- MWD  out  DW  memory write data
- MWE  out  2  memory write enable: 2'b01 = write, 2'b00 otherwise
- MRD  in  DW  registered memory read data
- IRWE  out  2  IR write enable: 2'b01 while F_RVALID, else 2'b00

## Operation
- One grant per cycle at most; F_GNT and D_GNT are never both 1.
- Priority, evaluated combinationally each cycle:
  - Only one requester asserts REQ: it wins, except F is blocked while the lock is held.
  - Both request: D wins, unless starve_cnt == STARVE_LIMIT and the lock is not held, in which case F wins.
- Lock:
  - The lock_held flag is set by a D grant with D_LOCK=1.
  - It is cleared on any cycle with D_LOCK=0.
  - While lock_held=1, F is never granted, even when starved.
- Starvation counter (starve_cnt, 4 bits, saturating at STARVE_LIMIT):
  - Increments each cycle F_REQ=1 and F_GNT=0.
  - Clears on F_GNT or F_REQ=0.
- Memory drive:
  - On the granted cycle, MRA is the winner's address.
  - MWE=2'b01 only for a D grant with D_WE=1.
  - MWD=D_WDATA always.
  - With no grant, MWE=0 and MRA holds its last value (registered shadow).
- Read return:
  - Registered return state, updated every edge:
    - IDLE: no read outstanding.
    - F_PEND: fetch read granted last cycle.
    - D_PEND: data read granted last cycle.
  - Next state is F_PEND on F_GNT, D_PEND on D_GNT&&!D_WE, IDLE otherwise.
  - In F_PEND: F_RVALID=1 and IRWE=2'b01. In D_PEND: D_RVALID=1.
  - RDATA=MRD always.
- Writes produce no RVALID.
- Back-to-back accesses are allowed. A read granted in the cycle after a write to the same address returns the new data.

## Timing
- Grant latency: 0 cycles. GNT, MRA and MWE are combinational from REQ and registered state.
- Read latency: RVALID exactly 1 cycle after GNT. There is no back-pressure, so the requester must capture RDATA in that cycle.
- Write latency: the memory is updated at the edge ending the D_GNT cycle.
- Reset (RST_N=0, asynchronous):
  - Return state=IDLE, starve_cnt=0, lock_held=0, MRA shadow=0.
  - F_GNT=D_GNT=0, MWE=0, F_RVALID=D_RVALID=0, IRWE=0 while in reset.
- Reset mid-read: the pending return is dropped and no RVALID follows.
- Request deasserted without a grant: legal, and no access occurs.

## Structure
- Shared package holds:
  - the return-state enum (IDLE, F_PEND, D_PEND);
  - the MWE/IRWE encodings (WE_ON=2'b01, WE_OFF=2'b00);
  - the default AW/DW values.
- Single module; no sub-module needed.

## Test plan
- F_REQ only, F_ADDR=20: F_GNT same cycle, MRA=20; next cycle F_RVALID=1, IRWE=2'b01, RDATA=17.
- F_REQ and D_REQ (read, addr 21) every cycle, STARVE_LIMIT=4: D granted 4 cycles, F granted on the 5th; each D_RVALID returns 31.
- D write 0x55 to addr 24, then D read of 24 the next cycle: MWE=2'b01 for one cycle; D_RVALID returns 0x55; no F_RVALID.
- D_LOCK=1 with F_REQ held for 8 cycles: F_GNT stays 0 despite starvation; F is granted the cycle after D_LOCK drops.
- RST_N low the cycle after a D read grant: D_RVALID stays 0, all outputs 0; after release, an F_REQ is granted immediately.
- Alternating F/D reads of addrs 22/23: grants every cycle; RDATA returns -5 and -2 with the correct RVALID each cycle.
